side_servo_pwm: RTL
===================

# side_servo_pwm

Two-channel servo pulse generator that sits directly downstream of the SideServos AXI4-Lite register slave. The register slave decodes the CPU writes. This block consumes the decoded enable bit and the two pulse-width words, clamps them to a safe range and double-buffers them so updates land only on frame boundaries. It then drives the two side-servo PWM pins with a fixed frame period.

## Interface
- TICK_DIV, 100: ACLK cycles per 1 µs tick (100 MHz ACLK).
- FRAME_US, 20000: frame period in ticks.
- MIN_US, 500: lower clamp for a non-zero width, in ticks.
- MAX_US, 2500: upper clamp for a width, in ticks.
- SLEW_US, 20: maximum width change per frame, in ticks; used only with the slew feature.
- ACLK  in  1  single clock, rising edge.
- ARESETN  in  1  reset, synchronous and active-low.
- enable_i  in  1  run request; driven from slv_reg0[0].
- pw0_i  in  16  channel 0 width in ticks; driven from slv_reg1[15:0].
- pw1_i  in  16  channel 1 width in ticks; driven from slv_reg2[15:0].
- cfg_wr_i  in  1  one-cycle strobe; latches pw0_i/pw1_i into the pending registers.
- pwm_o  out  2  servo outputs; bit k belongs to channel k.
- frame_o  out  1  one-cycle pulse at each frame start.
- clamp_o  out  2  sticky per channel: the last latched width was clamped.
- running_o  out  1  high in RUN and DRAIN.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- IDLE -> RUN when enable_i=1.
- RUN -> DRAIN when enable_i=0.
- DRAIN -> RUN when enable_i returns to 1. The current frame continues without a restart.
- DRAIN -> IDLE at the frame boundary.
- Pending width registers:
  - On cfg_wr_i, each channel is loaded with 0 if its input is 0 (channel off).
  - Otherwise it is loaded with the input clamped to [MIN_US, MAX_US].
  - clamp_o[k] is set when the value was altered by clamping. It is cleared by a later cfg_wr_i that needs no clamping on that channel.
- At each frame start, the active widths load from the pending registers.
- A cfg_wr_i on the same cycle as a frame start is latched into pending only. It takes effect in the next frame.
- pwm_o[k] is high while us_cnt < active[k]. If active[k]=0, the channel stays low.
- No runt pulses are allowed:
  - Disabling completes the current frame, including any pulse in progress.
  - The block then goes to IDLE.
- In IDLE, pwm_o=0 and all counters are held at 0.

## Timing
- Reset values: pwm_o=0, frame_o=0, clamp_o=0, running_o=0. State=IDLE. Pending and active widths=0. Counters=0.
- tick_cnt counts 0..TICK_DIV-1. A tick is generated on its terminal count.
- us_cnt advances on each tick and wraps from FRAME_US-1 to 0.
- Frame start occurs on the first RUN cycle after leaving IDLE, or on the cycle where us_cnt wraps to 0.
- frame_o is registered and is high for exactly one cycle, the cycle after the frame-start event.
- pwm_o is registered with 1-cycle latency. pwm_o[k] rises together with frame_o and stays high for exactly active[k]*TICK_DIV cycles.
- Latency from enable_i rising (sampled in IDLE) to pwm_o rising is 2 cycles.
- A reset asserted mid-frame forces the reset values on the next edge, with no drain.
- Widths satisfy MAX_US < FRAME_US, so pwm_o always falls before the frame ends.
- Comparators are 16-bit unsigned.

## Configuration
- `SIDE_SERVO_SLEW_EN` defined:
  - At each frame start, active[k] moves toward pending[k] by at most SLEW_US.
  - Moves to or from 0 are immediate.
- `SIDE_SERVO_SLEW_EN` undefined:
  - active[k] equals pending[k] at each frame start.
  - SLEW_US is unused.

## Structure
- Shared package side_servo_pkg holds:
  - the state enum {IDLE, RUN, DRAIN};
  - the width typedef pw_t (16-bit);
  - the default parameter constants.
- Sub-module side_servo_tick holds the TICK_DIV prescaler. It has a clear input, held in IDLE, and a tick output.
- The FSM, pending/active registers, clamp logic and comparators live in side_servo_pwm.

## Test plan
All scenarios run with TICK_DIV=2, FRAME_US=100, MIN_US=10, MAX_US=50, SLEW_US=5.
- Reset, then cfg_wr_i with pw0=20, pw1=30, then enable_i=1 -> pwm_o rises 2 cycles later. pwm_o[0] is high 40 cycles and pwm_o[1] 60 cycles. frame_o pulses every 200 cycles.
- cfg_wr_i with pw0=3, pw1=900 -> active widths become 10 and 50 at the next frame. clamp_o=2'b11. A later write of pw0=20, pw1=20 -> clamp_o=2'b00.
- cfg_wr_i on the exact frame-start cycle with pw0=40 (previous value 20) -> the current frame pulse is 40 cycles and the following frame pulse is 80 cycles.
- enable_i dropped at us_cnt=5 with width 20 -> the full 40-cycle pulse completes, no further pulse follows, and running_o falls at the frame end. Reasserting enable_i in DRAIN keeps frames contiguous.
- ARESETN=0 mid-pulse -> all outputs are 0 on the next edge. After release, pending=0 and both channels stay low after enable.
- With `SIDE_SERVO_SLEW_EN` defined, a step in pw0 from 20 to 40 -> successive active widths are 25, 30, 35, 40. Without the macro, the width goes straight to 40.

Source files
------------

// File: rtl/side_servo_pkg.sv
// -----------------------------------------------------------------------------
// side_servo_pkg
// Shared types and defaults for the two-channel side-servo PWM block.
//   state_e  : sequencer states {IDLE, RUN, DRAIN}
//   pw_t     : 16-bit pulse width / microsecond counter type
//   *_DEF    : default timing constants (100 MHz ACLK, 20 ms frame)
//   helpers  : width clamping and per-frame slew stepping
// Optional feature macro used by the block: SIDE_SERVO_SLEW_EN
// -----------------------------------------------------------------------------
package side_servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [15:0] pw_t;

  localparam int unsigned TICK_DIV_DEF = 100;
  localparam int unsigned FRAME_US_DEF = 20000;
  localparam int unsigned MIN_US_DEF   = 500;
  localparam int unsigned MAX_US_DEF   = 2500;
  localparam int unsigned SLEW_US_DEF  = 20;

  // Zero means "channel off" and is passed through untouched.
  function automatic pw_t clamp_width(input pw_t v, input pw_t lo, input pw_t hi);
    if (v == '0) return '0;
    if (v < lo)  return lo;
    if (v > hi)  return hi;
    return v;
  endfunction

  function automatic logic needs_clamp(input pw_t v, input pw_t lo, input pw_t hi);
    return (v != '0) && ((v < lo) || (v > hi));
  endfunction

  // Step act toward pend by at most step; switching a channel on or off is
  // always immediate. Sums are done in 17 bits so they cannot wrap.
  function automatic pw_t slew_width(input pw_t act, input pw_t pend, input pw_t step);
    logic [16:0] a17, p17, s17;
    a17 = {1'b0, act};
    p17 = {1'b0, pend};
    s17 = {1'b0, step};
    if ((act == '0) || (pend == '0)) return pend;
    if (p17 > a17 + s17)             return act + step;
    if (p17 + s17 < a17)             return act - step;
    return pend;
  endfunction

endpackage

// File: rtl/side_servo_tick.sv
// -----------------------------------------------------------------------------
// side_servo_tick
// Microsecond prescaler: counts 0..TICK_DIV-1 and flags the terminal count.
// Ports:
//   clk_i   : clock (ACLK of the parent)
//   rst_ni  : synchronous active-low reset
//   clr_i   : hold the counter at 0 (parent holds this while idle)
//   tick_o  : high on the terminal-count cycle, never while cleared
// -----------------------------------------------------------------------------
module side_servo_tick
  import side_servo_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/side_servo_pwm.sv
// -----------------------------------------------------------------------------
// side_servo_pwm
// Two-channel servo pulse generator fed by the SideServos register slave.
// Widths are clamped on write into pending registers and copied into the
// active registers only at frame starts, so a pulse is never cut or stretched.
//
// Ports:
//   ACLK       : clock, rising edge
//   ARESETN    : synchronous active-low reset (no drain, immediate)
//   enable_i   : run request
//   pw0_i/pw1_i: requested widths in ticks, 0 = channel off
//   cfg_wr_i   : one-cycle strobe latching pw0_i/pw1_i into pending
//   pwm_o[k]   : servo pulse for channel k (registered)
//   frame_o    : one-cycle pulse aligned with the start of each frame
//   clamp_o[k] : last latched width for channel k was altered by clamping
//   running_o  : sequencer is in RUN or DRAIN
//
// Optional feature: define SIDE_SERVO_SLEW_EN to limit the per-frame change of
// a non-zero active width to SLEW_US ticks.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | counters held at 0, outputs low, waiting for enable_i
// RUN   | frames repeat back to back
// DRAIN | enable dropped; finish the current frame, then go idle
// -----------------------------------------------------------------------------
module side_servo_pwm
  import side_servo_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned FRAME_US = FRAME_US_DEF,
  parameter int unsigned MIN_US   = MIN_US_DEF,
  parameter int unsigned MAX_US   = MAX_US_DEF,
  parameter int unsigned SLEW_US  = SLEW_US_DEF
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable_i,
  input  logic [15:0] pw0_i,
  input  logic [15:0] pw1_i,
  input  logic        cfg_wr_i,
  output logic [1:0]  pwm_o,
  output logic        frame_o,
  output logic [1:0]  clamp_o,
  output logic        running_o
);

  localparam pw_t FRAME_LAST = pw_t'(FRAME_US - 1);
  localparam pw_t MIN_W      = pw_t'(MIN_US);
  localparam pw_t MAX_W      = pw_t'(MAX_US);
`ifdef SIDE_SERVO_SLEW_EN
  localparam pw_t SLEW_STEP  = pw_t'(SLEW_US);
`else
  // A step at least as large as the whole clamp range turns the slew helper
  // into a straight copy: any move between legal widths lands in one frame.
  localparam pw_t SLEW_STEP  = pw_t'((SLEW_US > MAX_US) ? SLEW_US : MAX_US);
`endif

  state_e     state_q, state_d;
  logic       start_q, start_d;
  pw_t        us_cnt_q, us_cnt_d;
  pw_t [1:0]  pend_q, pend_d;
  pw_t [1:0]  act_q, act_d;
  logic [1:0] clamp_q, clamp_d;
  logic [1:0] pwm_q, pwm_d;
  logic       frame_q, frame_d;
  logic       running_q, running_d;

  pw_t [1:0]  pw_in;
  logic       tick;
  logic       tick_clr;
  logic       frame_end;

  assign pw_in[0] = pw0_i;
  assign pw_in[1] = pw1_i;

  assign tick_clr = (state_q == IDLE);

  side_servo_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Last cycle of a frame: the tick that wraps us_cnt back to 0.
  assign frame_end = (state_q != IDLE) && tick && (us_cnt_q == FRAME_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        // Dropping enable on the very last cycle means the frame is already
        // complete, so there is nothing left to drain.
        if (!enable_i) state_d = frame_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable_i)       state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The cycle following this one is a frame start.
    start_d = (state_d == RUN) && ((state_q == IDLE) || frame_end);

    if (state_q == IDLE) begin
      us_cnt_d = '0;
    end else if (tick) begin
      us_cnt_d = frame_end ? '0 : us_cnt_q + 16'd1;
    end else begin
      us_cnt_d = us_cnt_q;
    end

    frame_d   = start_q;
    running_d = (state_d != IDLE);

    pend_d  = pend_q;
    clamp_d = clamp_q;
    act_d   = act_q;
    pwm_d   = '0;
    for (int k = 0; k < 2; k++) begin
      if (cfg_wr_i) begin
        pend_d[k]  = clamp_width(pw_in[k], MIN_W, MAX_W);
        clamp_d[k] = needs_clamp(pw_in[k], MIN_W, MAX_W);
      end
      // Active loads from the pending value held before this cycle, so a
      // write landing on a frame start only affects the next frame.
      if (start_q) begin
        act_d[k] = slew_width(act_q[k], pend_q[k], SLEW_STEP);
      end
      // act_d (not act_q) so the first cycle of a frame already sees the
      // freshly loaded width.
      pwm_d[k] = (state_q != IDLE) && (us_cnt_q < act_d[k]);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      us_cnt_q  <= '0;
      pend_q    <= '0;
      act_q     <= '0;
      clamp_q   <= '0;
      pwm_q     <= '0;
      frame_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      us_cnt_q  <= us_cnt_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      clamp_q   <= clamp_d;
      pwm_q     <= pwm_d;
      frame_q   <= frame_d;
      running_q <= running_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign frame_o   = frame_q;
  assign clamp_o   = clamp_q;
  assign running_o = running_q;

endmodule
